// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
// Contents:
//   - Stall vector constants. Bit order is pc, if, id, ex, mem, wb
//     (bit0 is pc, bit5 is wb).
//   - Sequencer state encodings.
//   - Default counter and address widths.
//   - Helper function that maps the winning stall source to its stall vector.
package pipe_ctrl_pkg;

  localparam int CntWDefault  = 6;
  localparam int AddrWDefault = 32;

  // A stall freezes every stage up to and including the named stage.
  // The stage after it receives a bubble.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallRom  = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;

  localparam logic [1:0] CtrlRun    = 2'd0;
  localparam logic [1:0] CtrlExBusy = 2'd1;
  localparam logic [1:0] CtrlFlush  = 2'd2;

  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcEx   = 2'd1,
    SrcId   = 2'd2,
    SrcRom  = 2'd3
  } stall_src_e;

  function automatic logic [5:0] stall_vec(input stall_src_e src);
    logic [5:0] vec;
    vec = StallNone;
    case (src)
      SrcEx:   vec = StallEx;
      SrcId:   vec = StallId;
      SrcRom:  vec = StallRom;
      default: vec = StallNone;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_ex_busy_cnt.sv
// ex_busy_cnt
// Loadable saturating down-counter. It tracks the busy cycles that remain
// for a multi-cycle execute operation.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   load      - load load_val into the counter
//   load_val  - number of busy cycles to count down
//   abort     - force the counter to zero; takes priority over load
//   busy      - counter is non-zero
//   last      - counter is at 1, so this cycle is the final decrement
module ex_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             abort,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Abort wins over load. The decrement stops at zero, so the counter can
  // never wrap around to all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central stall/flush sequencer for the five-stage integer pipeline.
// It arbitrates three stall sources:
//   - a decode load-use bubble
//   - multi-cycle execute operations
//   - instruction ROM not ready
// It also turns a flush request into a registered one-cycle flush pulse
// that carries the redirect PC.
// Optional feature: define PIPE_CTRL_PERF_EN to add 32-bit performance
// counters for each stall cause and for flush cycles.
// Ports:
//   clk, rst          - clock and asynchronous active-low reset
//   stallreq_id       - decode needs a one-cycle bubble
//   ex_multi_start    - execute starts a multi-cycle op (pulse)
//   ex_multi_cycles   - extra busy cycles for that op
//   rom_ready         - instruction ROM data valid
//   flush_req         - exception/redirect request (pulse)
//   flush_pc          - redirect target, sampled with flush_req
//   stall[5:0]        - per-stage stall: pc, if, id, ex, mem, wb
//   flush             - registered flush pulse
//   new_pc            - registered redirect target
//   ex_busy           - multi-cycle op outstanding
//   perf_*            - performance counters (PIPE_CTRL_PERF_EN only)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = CntWDefault,
  parameter int ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_multi_start,
  input  logic [CNT_W-1:0]  ex_multi_cycles,
  input  logic              rom_ready,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              ex_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_ex,
  output logic [31:0]       perf_stall_id,
  output logic [31:0]       perf_stall_rom,
  output logic [31:0]       perf_flush
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        start_nz;
  logic        cnt_load;
  logic        cnt_busy;
  logic        cnt_last;
  stall_src_e  stall_src;

  assign start_nz = ex_multi_start && (ex_multi_cycles != '0);

  // The counter is loaded only from RUN. A start that arrives while busy
  // is a protocol error and is dropped. A start in the same cycle as a
  // flush is also dropped, because the flush takes priority.
  assign cnt_load = (state == CtrlRun) && start_nz && !flush_req;

  ex_busy_cnt #(
    .CNT_W(CNT_W)
  ) u_ex_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (ex_multi_cycles),
    .abort    (flush_req),
    .busy     (cnt_busy),
    .last     (cnt_last)
  );

  // Next-state logic. A flush request always wins. FLUSH lasts a single
  // cycle unless another flush request arrives while in FLUSH.
  always_comb begin
    state_nxt = state;
    case (state)
      CtrlRun: begin
        if (flush_req)     state_nxt = CtrlFlush;
        else if (start_nz) state_nxt = CtrlExBusy;
      end
      CtrlExBusy: begin
        if (flush_req)     state_nxt = CtrlFlush;
        else if (cnt_last) state_nxt = CtrlRun;
      end
      CtrlFlush: begin
        state_nxt = flush_req ? CtrlFlush : CtrlRun;
      end
      default: state_nxt = CtrlRun;
    endcase
  end

  // The state register and the flush pulse share one register stage, so
  // flush tracks the FLUSH state exactly. new_pc holds its value between
  // flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CtrlRun;
      flush  <= 1'b0;
      new_pc <= '0;
    end else begin
      state <= state_nxt;
      flush <= flush_req;
      if (flush_req) begin
        new_pc <= flush_pc;
      end
    end
  end

  // Stall arbitration, highest priority first:
  //   1. FLUSH produces no stall.
  //   2. A multi-cycle execute op stalls pc through ex.
  //   3. A decode bubble.
  //   4. ROM not ready.
  always_comb begin
    stall_src = SrcNone;
    if (state == CtrlFlush) begin
      stall_src = SrcNone;
    end else if ((state == CtrlExBusy) || ((state == CtrlRun) && start_nz)) begin
      stall_src = SrcEx;
    end else if (stallreq_id) begin
      stall_src = SrcId;
    end else if (!rom_ready) begin
      stall_src = SrcRom;
    end
  end

  assign stall   = stall_vec(stall_src);
  assign ex_busy = cnt_busy;

`ifdef PIPE_CTRL_PERF_EN
  // Each counter advances once per cycle in which its cause wins the
  // arbitration. The flush counter advances once per cycle in which flush
  // is high. All counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_ex  <= '0;
      perf_stall_id  <= '0;
      perf_stall_rom <= '0;
      perf_flush     <= '0;
    end else begin
      if (stall_src == SrcEx)  perf_stall_ex  <= perf_stall_ex + 32'd1;
      if (stall_src == SrcId)  perf_stall_id  <= perf_stall_id + 32'd1;
      if (stall_src == SrcRom) perf_stall_rom <= perf_stall_rom + 32'd1;
      if (flush)               perf_flush     <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
